// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with iterative shift-add multiply and restoring divide
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 8
) (
  input  logic             I_clk,
  input  logic             I_reset,
  input  logic             I_valid,
  output logic             O_ready,
  input  logic [3:0]       I_opcode,
  input  logic             I_signed,
  input  logic             I_use_imm,
  input  logic [IMM_W-1:0] I_immediate,
  input  logic [WIDTH-1:0] I_rA,
  input  logic [WIDTH-1:0] I_rB,
  output logic             O_valid,
  input  logic             I_ready,
  output logic [WIDTH-1:0] O_out,
  output logic [5:0]       O_flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam int M   = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_MULH = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_REM  = 4'd11;
  localparam logic [3:0] OP_CMP  = 4'd12;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_next;

  // Operation context captured at accept
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic [WIDTH-1:0]   mb_q;
  logic [2*WIDTH-1:0] work_q;
  logic               neg_q;
  logic               rneg_q;
  logic               div0_q;
  logic               ovf_q;
  logic [SHW-1:0]     cnt_q;

  logic [WIDTH-1:0] imm_sext, imm_zext, op_a, op_b, mag_a, mag_b, min_val;
  logic [SHW-1:0]   shamt;
  logic             big_shift, gt_ab, gt_ba, is_mul, is_div, last_iter;
  logic [WIDTH:0]   add_full, sub_full;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  assign imm_sext  = WIDTH'($signed(I_immediate));
  assign imm_zext  = WIDTH'(I_immediate);
  assign op_a      = I_rA;
  assign op_b      = I_use_imm ? (I_signed ? imm_sext : imm_zext) : I_rB;
  assign min_val   = {1'b1, {(WIDTH-1){1'b0}}};
  assign shamt     = op_b[SHW-1:0];
  assign big_shift = |op_b[WIDTH-1:SHW];
  assign add_full  = {1'b0, op_a} + {1'b0, op_b};
  assign sub_full  = {1'b0, op_a} - {1'b0, op_b};
  assign gt_ab     = I_signed ? ($signed(op_a) > $signed(op_b)) : (op_a > op_b);
  assign gt_ba     = I_signed ? ($signed(op_b) > $signed(op_a)) : (op_b > op_a);
  assign is_mul    = (I_opcode == OP_MUL) || (I_opcode == OP_MULH);
  assign is_div    = (I_opcode == OP_DIV) || (I_opcode == OP_REM);
  assign mag_a     = magnitude(op_a, I_signed);
  assign mag_b     = magnitude(op_b, I_signed);
  assign last_iter = (cnt_q == SHW'(WIDTH - 1));

  assign O_ready = (state == IDLE);
  assign O_valid = (state == DONE);

  logic [WIDTH-1:0] alu_out;
  logic [5:0]       alu_flags;
  logic             alu_c, alu_v, alu_ill;

  // Single-cycle operations evaluated directly from the request inputs
  always_comb begin
    alu_out = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (I_opcode)
      OP_ADD: begin
        alu_out = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (op_a[M] == op_b[M]) && (add_full[M] != op_a[M]);
      end
      OP_SUB: begin
        alu_out = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (op_a[M] != op_b[M]) && (sub_full[M] != op_a[M]);
      end
      OP_AND:  alu_out = op_a & op_b;
      OP_OR:   alu_out = op_a | op_b;
      OP_XOR:  alu_out = op_a ^ op_b;
      OP_NOT:  alu_out = ~op_a;
      OP_SHL:  alu_out = big_shift ? '0 : (op_a << shamt);
      OP_SHR: begin
        if (big_shift)
          alu_out = (I_signed && op_a[M]) ? '1 : '0;
        else if (I_signed)
          alu_out = $signed(op_a) >>> shamt;
        else
          alu_out = op_a >> shamt;
      end
      OP_CMP: begin
        alu_out[0] = gt_ba;
        alu_out[1] = gt_ab;
        alu_out[2] = (op_a == op_b);
        alu_out[3] = (op_a == '0);
        alu_out[4] = (op_b == '0);
      end
      OP_MUL, OP_MULH, OP_DIV, OP_REM: alu_out = '0;
      default: alu_ill = 1'b1;
    endcase
    alu_flags = {alu_ill, 1'b0, alu_v, alu_c, ~alu_ill & alu_out[M], ~alu_ill & (alu_out == '0)};
  end

  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] work_next;

  // One multiply or divide iteration; work holds {acc, multiplier} or {remainder, quotient}
  always_comb begin
    mul_sum   = '0;
    div_shift = '0;
    div_diff  = '0;
    work_next = work_q;
    if (state == MUL) begin
      mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, mb_q} : '0);
      work_next = {mul_sum, work_q[WIDTH-1:1]};
    end else if (state == DIV) begin
      div_shift = work_q[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift[WIDTH-1:0] - mb_q;
      if (div_shift >= {1'b0, mb_q})
        work_next = {div_diff, work_q[WIDTH-2:0], 1'b1};
      else
        work_next = {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem, fin_out;
  logic [5:0]         fin_flags;

  // Sign correction and special cases applied to the final iteration's result
  always_comb begin
    prod = neg_q ? (~work_next + 1'b1) : work_next;
    if (div0_q) begin
      quot = '1;
      rem  = a_raw_q;
    end else if (ovf_q) begin
      quot = min_val;
      rem  = '0;
    end else begin
      quot = neg_q  ? (~work_next[WIDTH-1:0] + 1'b1) : work_next[WIDTH-1:0];
      rem  = rneg_q ? (~work_next[2*WIDTH-1:WIDTH] + 1'b1) : work_next[2*WIDTH-1:WIDTH];
    end
    if (state == MUL)
      fin_out = (op_q == OP_MULH) ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    else
      fin_out = (op_q == OP_REM) ? rem : quot;
    fin_flags = {1'b0, div0_q, ovf_q, 1'b0, fin_out[M], fin_out == '0};
  end

  // State register
  always_ff @(posedge I_clk) begin
    if (I_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state decode; results leave DONE only on the consumer handshake
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (I_valid) begin
          if (is_mul)      state_next = MUL;
          else if (is_div) state_next = DIV;
          else             state_next = DONE;
        end
      end
      MUL:     if (last_iter) state_next = DONE;
      DIV:     if (last_iter) state_next = DONE;
      DONE:    if (I_ready)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration, and result registers
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      op_q    <= '0;
      a_raw_q <= '0;
      mb_q    <= '0;
      work_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      O_out   <= '0;
      O_flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (I_valid) begin
            op_q    <= I_opcode;
            a_raw_q <= op_a;
            mb_q    <= mag_b;
            work_q  <= {{WIDTH{1'b0}}, mag_a};
            neg_q   <= I_signed && (op_a[M] ^ op_b[M]);
            rneg_q  <= I_signed && op_a[M];
            div0_q  <= is_div && (op_b == '0);
            ovf_q   <= is_div && I_signed && (op_a == min_val) && (op_b == '1);
            cnt_q   <= '0;
            if (!is_mul && !is_div) begin
              O_out   <= alu_out;
              O_flags <= alu_flags;
            end
          end
        end
        MUL, DIV: begin
          work_q <= work_next;
          cnt_q  <= cnt_q + 1'b1;
          if (last_iter) begin
            O_out   <= fin_out;
            O_flags <= fin_flags;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with directed vectors
module tb_alu_seq;

  logic        I_clk = 1'b0;
  logic        I_reset;
  logic        I_valid;
  logic        O_ready;
  logic [3:0]  I_opcode;
  logic        I_signed;
  logic        I_use_imm;
  logic [7:0]  I_immediate;
  logic [15:0] I_rA;
  logic [15:0] I_rB;
  logic        O_valid;
  logic        I_ready;
  logic [15:0] O_out;
  logic [5:0]  O_flags;

  alu_seq #(.WIDTH(16), .IMM_W(8)) dut (
    .I_clk(I_clk), .I_reset(I_reset), .I_valid(I_valid), .O_ready(O_ready),
    .I_opcode(I_opcode), .I_signed(I_signed), .I_use_imm(I_use_imm),
    .I_immediate(I_immediate), .I_rA(I_rA), .I_rB(I_rB), .O_valid(O_valid),
    .I_ready(I_ready), .O_out(O_out), .O_flags(O_flags)
  );

  always #5 I_clk = ~I_clk;

  int cycle = 0;
  always @(posedge I_clk) cycle <= cycle + 1;

  typedef struct {
    logic [15:0] out;
    logic [5:0]  flags;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: latency on first valid, payload on handshake
  initial begin
    exp_t e;
    bit   seen = 0;
    forever begin
      @(negedge I_clk);
      if (I_reset) seen = 0;
      else if (O_valid === 1'b1) begin
        if (sb.size() == 0) begin
          if (I_ready) check("unexpected_valid", 32'(O_valid), 32'd0);
        end else begin
          if (!seen) begin
            seen = 1;
            check({sb[0].name, "_lat"}, 32'(cycle - sb[0].acc + 1), 32'(sb[0].lat));
          end
          if (I_ready) begin
            e = sb.pop_front();
            seen = 0;
            check({e.name, "_out"}, 32'(O_out), 32'(e.out));
            check({e.name, "_flags"}, 32'(O_flags), 32'(e.flags));
          end
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge I_clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check({name, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
      I_reset = 1'b1;
      @(posedge I_clk); #1;
      I_reset = 1'b0;
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] opc, input logic sgn,
                        input logic ui, input logic [7:0] imm, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] eo, input logic [5:0] ef,
                        input int lat, input logic rdy = 1'b1);
    I_opcode = opc; I_signed = sgn; I_use_imm = ui; I_immediate = imm;
    I_rA = a; I_rB = b; I_ready = rdy; I_valid = 1'b1;
    @(negedge I_clk);
    check({name, "_ready"}, 32'(O_ready), 32'd1);
    @(posedge I_clk); #1;
    I_valid = 1'b0;
    sb.push_back('{out: eo, flags: ef, lat: lat, acc: cycle, name: name});
    if (rdy) wait_drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    I_reset = 1'b1; I_valid = 1'b1; I_opcode = 4'd0; I_signed = 1'b0; I_use_imm = 1'b0;
    I_immediate = 8'h00; I_rA = 16'h0001; I_rB = 16'h0001; I_ready = 1'b1;
    repeat (2) @(posedge I_clk);
    #1;
    I_reset = 1'b0; I_valid = 1'b0;
    @(negedge I_clk);
    check("rst_valid", 32'(O_valid), 32'd0);
    check("rst_ready", 32'(O_ready), 32'd1);
    check("rst_out",   32'(O_out),   32'd0);
    check("rst_flags", 32'(O_flags), 32'd0);
    @(posedge I_clk); #1;

    //     name         op  s  imm   imm    A        B        out      flags  lat
    run_op("add_ovf",   0, 1, 0, 8'h00, 16'h7FFF, 16'h0001, 16'h8000, 6'h0A, 1);
    run_op("add_carry", 0, 0, 0, 8'h00, 16'hFFFF, 16'h0001, 16'h0000, 6'h05, 1);
    run_op("sub_borrow",1, 0, 0, 8'h00, 16'h0003, 16'h0005, 16'hFFFE, 6'h06, 1);
    run_op("sub_ovf",   1, 1, 0, 8'h00, 16'h8000, 16'h0001, 16'h7FFF, 6'h08, 1);
    run_op("addimm_s",  0, 1, 1, 8'hFE, 16'h0005, 16'h7777, 16'h0003, 6'h04, 1);
    run_op("addimm_u",  0, 0, 1, 8'hFE, 16'h0005, 16'h7777, 16'h0103, 6'h00, 1);
    run_op("and",       2, 0, 0, 8'h00, 16'hF0F0, 16'hFF00, 16'hF000, 6'h02, 1);
    run_op("or",        3, 0, 0, 8'h00, 16'hF0F0, 16'hFF00, 16'hFFF0, 6'h02, 1);
    run_op("xor",       4, 0, 0, 8'h00, 16'hF0F0, 16'hFF00, 16'h0FF0, 6'h00, 1);
    run_op("not",       5, 0, 0, 8'h00, 16'h00FF, 16'h1234, 16'hFF00, 6'h02, 1);
    run_op("shl_big",   6, 0, 0, 8'h00, 16'h0001, 16'h0010, 16'h0000, 6'h01, 1);
    run_op("sra4",      7, 1, 0, 8'h00, 16'h8000, 16'h0004, 16'hF800, 6'h02, 1);
    run_op("shr_u4",    7, 0, 0, 8'h00, 16'h8000, 16'h0004, 16'h0800, 6'h00, 1);
    run_op("sra_big",   7, 1, 0, 8'h00, 16'h8000, 16'h0014, 16'hFFFF, 6'h02, 1);
    run_op("cmp_s",    12, 1, 0, 8'h00, 16'hFFFF, 16'h0001, 16'h0001, 6'h00, 1);
    run_op("cmp_u",    12, 0, 0, 8'h00, 16'hFFFF, 16'h0001, 16'h0002, 6'h00, 1);
    run_op("cmp_zero", 12, 0, 0, 8'h00, 16'h0000, 16'h0000, 16'h001C, 6'h00, 1);
    run_op("illegal",  13, 0, 0, 8'h00, 16'h1234, 16'h5678, 16'h0000, 6'h20, 1);
    run_op("mul_u",     8, 0, 0, 8'h00, 16'h1234, 16'h0010, 16'h2340, 6'h00, 17);
    run_op("mulh_u",    9, 0, 0, 8'h00, 16'h1234, 16'h0010, 16'h0001, 6'h00, 17);
    run_op("mul_s",     8, 1, 0, 8'h00, 16'hFFFE, 16'h0003, 16'hFFFA, 6'h02, 17);
    run_op("mulh_s",    9, 1, 0, 8'h00, 16'hFFFE, 16'h0003, 16'hFFFF, 6'h02, 17);
    run_op("div_s",    10, 1, 0, 8'h00, 16'hFFF9, 16'h0002, 16'hFFFD, 6'h02, 17);
    run_op("rem_s",    11, 1, 0, 8'h00, 16'hFFF9, 16'h0002, 16'hFFFF, 6'h02, 17);
    run_op("div_u",    10, 0, 0, 8'h00, 16'hFFF9, 16'h0002, 16'h7FFC, 6'h00, 17);
    run_op("div_min",  10, 1, 0, 8'h00, 16'h8000, 16'hFFFF, 16'h8000, 6'h0A, 17);
    run_op("rem_min",  11, 1, 0, 8'h00, 16'h8000, 16'hFFFF, 16'h0000, 6'h09, 17);
    run_op("div0_u",   10, 0, 0, 8'h00, 16'h0064, 16'h0000, 16'hFFFF, 6'h12, 17);
    run_op("rem0_u",   11, 0, 0, 8'h00, 16'h0064, 16'h0000, 16'h0064, 6'h10, 17);
    run_op("div0_s",   10, 1, 0, 8'h00, 16'hFFF9, 16'h0000, 16'hFFFF, 6'h12, 17);
    run_op("rem0_s",   11, 1, 0, 8'h00, 16'hFFF9, 16'h0000, 16'hFFF9, 6'h12, 17);

    // Back-pressure: result must hold and new requests must be refused
    run_op("stall_add", 0, 0, 0, 8'h00, 16'h1111, 16'h2222, 16'h3333, 6'h00, 1, 1'b0);
    I_valid = 1'b1; I_opcode = 4'd1; I_rA = 16'h0F0F; I_rB = 16'h0101;
    repeat (5) begin
      @(negedge I_clk);
      check("stall_valid", 32'(O_valid), 32'd1);
      check("stall_out",   32'(O_out),   32'h3333);
      check("stall_ready", 32'(O_ready), 32'd0);
      @(posedge I_clk); #1;
    end
    I_valid = 1'b0; I_ready = 1'b1;
    wait_drain("stall_add");
    @(negedge I_clk);
    check("stall_no_accept", 32'(O_valid), 32'd0);
    @(posedge I_clk); #1;

    // Reset in the middle of a divide aborts it without a result
    I_opcode = 4'd10; I_signed = 1'b0; I_use_imm = 1'b0; I_rA = 16'd100; I_rB = 16'd7;
    I_valid = 1'b1;
    @(negedge I_clk);
    check("abort_ready", 32'(O_ready), 32'd1);
    @(posedge I_clk); #1;
    I_valid = 1'b0;
    repeat (8) @(posedge I_clk);
    #1;
    I_reset = 1'b1;
    @(posedge I_clk); #1;
    I_reset = 1'b0;
    @(negedge I_clk);
    check("abort_valid", 32'(O_valid), 32'd0);
    check("abort_ready_after", 32'(O_ready), 32'd1);
    check("abort_out", 32'(O_out), 32'd0);
    @(posedge I_clk); #1;
    run_op("post_abort_add", 0, 0, 0, 8'h00, 16'h0002, 16'h0003, 16'h0005, 6'h00, 1);

    repeat (3) @(posedge I_clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width (≥8, power of two).
REQ-002 SHALL have parameter IMM_W, default 8, immediate width (≤WIDTH).
REQ-003 SHALL have ports: I_clk  in  1  clock; I_reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have I_valid  in  1  request valid; O_ready  out  1  request accepted when I_valid&&O_ready at rising edge.
REQ-005 SHALL have I_opcode  in  4  operation; I_signed  in  1  signed mode; I_use_imm  in  1  operand B from immediate.
REQ-006 SHALL have I_immediate  in  IMM_W; I_rA  in  WIDTH; I_rB  in  WIDTH  operands.
REQ-007 SHALL have O_valid  out  1  result valid; I_ready  in  1  result consumed when O_valid&&I_ready at edge.
REQ-008 SHALL have O_out  out  WIDTH  result; O_flags  out  6  {ILL,D,V,C,N,Z} (bit5..0).

Function
REQ-009 Operand B SHALL be I_rB, or when I_use_imm the immediate sign-extended (I_signed=1) or zero-extended to WIDTH; operands SHALL be captured at accept.
REQ-010 Opcodes SHALL be: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOT(A),6 SHL,7 SHR (arithmetic if signed),8 MUL(low),9 MULH(high),10 DIV,11 REM,12 CMP; 13-15 illegal -> O_out=0, ILL=1.
REQ-011 FSM states SHALL be IDLE, MUL, DIV, DONE; O_ready=1 only in IDLE; requests outside IDLE SHALL be ignored.
REQ-012 Ops 0-7,12 and illegal SHALL go IDLE->DONE; result/flags registered at accept edge k, O_valid=1 from edge k+1.
REQ-013 MUL/MULH SHALL use iterative shift-add, one bit per cycle, WIDTH iterations; DIV/REM iterative restoring, WIDTH iterations; O_valid=1 from edge k+WIDTH+1.
REQ-014 Signed MUL/DIV SHALL operate on magnitudes and correct sign at end; DIV truncates toward zero, REM takes sign of dividend.
REQ-015 MULH SHALL return bits [2*WIDTH-1:WIDTH] of the full signed/unsigned product.
REQ-016 Divide by zero SHALL give quotient all-ones, remainder = A, D=1, latency unchanged.
REQ-017 Signed MIN/-1 SHALL give quotient MIN, remainder 0, V=1.
REQ-018 Shift amount SHALL be B unsigned; amount ≥WIDTH gives 0 (SHL, logical SHR) or all sign bits (arithmetic SHR).
REQ-019 CMP result SHALL be bit0 B>A, bit1 A>B, bit2 A==B, bit3 A==0, bit4 B==0 (signed/unsigned per I_signed), upper bits 0.
REQ-020 Z SHALL be O_out==0, N SHALL be O_out MSB for all legal ops; C = carry (ADD) or borrow (SUB), else 0; V = signed overflow for ADD/SUB (any mode), else per REQ-017.
REQ-021 In DONE, O_out/O_flags/O_valid SHALL hold stable until I_ready; on handshake edge O_valid->0, state->IDLE.
REQ-022 No new request SHALL be accepted on the same edge as the result handshake (min 2 cycles per op).

Reset
REQ-023 With I_reset high at an edge: state=IDLE, O_valid=0, O_out=0, O_flags=0, iteration counter=0; I_valid ignored that edge.
REQ-024 Reset mid-MUL/DIV SHALL abort the operation with no result produced; O_ready=1 from the following cycle.

Verification (WIDTH=16, IMM_W=8)
REQ-025 ADD signed 0x7FFF+0x0001 -> O_out=0x8000, V=1, N=1, C=0, O_valid at k+1.
REQ-026 MUL unsigned 0x1234*0x0010 -> 0x2340; MULH same operands -> 0x0001; O_valid exactly at k+17.
REQ-027 DIV signed 0xFFF9/0x0002 -> 0xFFFD; REM -> 0xFFFF; DIV 0x8000/0xFFFF -> 0x8000, V=1.
REQ-028 DIV unsigned 100/0 -> 0xFFFF, D=1; REM 100/0 -> 0x0064, D=1.
REQ-029 ADD with I_use_imm, imm=0xFE, signed, A=5 -> 0x0003; unsigned -> 0x0103.
REQ-030 Hold I_ready=0 for 5 cycles after O_valid, drive I_valid=1 -> O_out stable, O_ready=0, no accept; reset at DIV iteration 8 -> O_valid=0, next ADD correct.
